// File: rtl/dcache_2way.sv
// dcache_2way: two-way set-associative write-back data cache with word-serial refill and halt flush
module dcache_2way (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    typedef enum logic [2:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH, FLUSHED} state_t;
    state_t state_q, state_d;
    logic [7:0][1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [7:0][1:0][25:0] tag_q, tag_d;
    logic [7:0][1:0][1:0][31:0] data_q, data_d;
    logic [7:0] lru_q, lru_d;
    logic victim_q, victim_d, word_q, word_d;
    logic [3:0] cnt_q, cnt_d;
    logic [25:0] tag;
    logic [2:0] idx, fset;
    logic off, fway, hit0, hit1, hway, req, unused_ok;
    assign tag = dmemaddr[31:6];
    assign idx = dmemaddr[5:3];
    assign off = dmemaddr[2];
    assign unused_ok = ^dmemaddr[1:0];
    assign req = dmemREN | dmemWEN;
    assign hit0 = valid_q[idx][0] && tag_q[idx][0] == tag;
    assign hit1 = valid_q[idx][1] && tag_q[idx][1] == tag;
    assign hway = ~hit0;
    assign fset = cnt_q[3:1];
    assign fway = cnt_q[0];
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            lru_q    <= '0;
            victim_q <= 1'b0;
            word_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        tag_d    = tag_q;
        data_d   = data_q;
        lru_d    = lru_q;
        victim_d = victim_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                end else if (req && (hit0 || hit1)) begin
                    dhit = 1'b1;
                    dmemload = dmemWEN ? '0 : data_q[idx][hway][off];
                    lru_d[idx] = ~hway;
                    if (dmemWEN) begin
                        data_d[idx][hway][off] = dmemstore;
                        dirty_d[idx][hway] = 1'b1;
                    end
                end else if (req) begin
                    victim_d = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
                    state_d = dirty_q[idx][victim_d] ? WB0 : LD0;
                end
            end
            WB0, WB1: begin
                dWEN = 1'b1;
                daddr = {tag_q[idx][victim_q], idx, state_q == WB1, 2'b00};
                dstore = data_q[idx][victim_q][state_q == WB1];
                if (!dwait) state_d = state_q == WB0 ? WB1 : LD0;
            end
            LD0, LD1: begin
                dREN = 1'b1;
                daddr = {tag, idx, state_q == LD1, 2'b00};
                if (!dwait) begin
                    data_d[idx][victim_q][state_q == LD1] = dload;
                    state_d = state_q == LD0 ? LD1 : IDLE;
                    if (state_q == LD1) begin
                        valid_d[idx][victim_q] = 1'b1;
                        dirty_d[idx][victim_q] = 1'b0;
                        tag_d[idx][victim_q] = tag;
                    end
                end
            end
            FLUSH: begin
                if (dirty_q[fset][fway]) begin
                    dWEN = 1'b1;
                    daddr = {tag_q[fset][fway], fset, word_q, 2'b00};
                    dstore = data_q[fset][fway][word_q];
                    if (!dwait) begin
                        word_d = ~word_q;
                        if (word_q) begin
                            dirty_d[fset][fway] = 1'b0;
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q == 4'hf) state_d = FLUSHED;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'hf) state_d = FLUSHED;
                end
            end
            FLUSHED: flushed = 1'b1;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: random and directed checks of dcache_2way against a transparent-cache reference model
module tb_dcache_2way;
    logic        CLK = 1'b0;
    logic        nRST, halt, dmemREN, dmemWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_2way dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] mem  [logic [29:0]];
    logic [31:0] gold [logic [29:0]];
    bit          m_valid [8][2];
    bit          m_dirty [8][2];
    logic [25:0] m_tag   [8][2];
    int          m_time  [8][2];
    int          now_t = 0;
    logic [31:0] rd_log[$], wr_log[$], wd_log[$];
    bit          rnd = 0, stalled_prev = 0;
    int          stall_per = 0, stall_cnt = 0, nstall = 0;
    logic [31:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [29:0] w);
        return {w[15:0] ^ 16'hC0DE, w[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : init_val(a[31:2]);
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return gold.exists(a[31:2]) ? gold[a[31:2]] : init_val(a[31:2]);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w] = '0;
                m_time[s][w] = 0;
            end
        gold = mem;
    endfunction

    // Called at the negedge: acts as the memory for one cycle.
    task automatic mem_cycle();
        if (dREN || dWEN) begin
            chk("ren_wen_exclusive", 32'(dREN & dWEN), 0);
            if (stalled_prev) chk("daddr_stable", daddr, prev_addr);
            dwait = rnd ? ($urandom_range(0, 2) == 0) : (stall_cnt < stall_per);
            dload = $urandom;
            if (dwait) begin
                stall_cnt++;
                nstall++;
            end else begin
                stall_cnt = 0;
                if (dREN) begin
                    dload = mem_rd(daddr);
                    rd_log.push_back(daddr);
                end else begin
                    mem[daddr[31:2]] = dstore;
                    wr_log.push_back(daddr);
                    wd_log.push_back(dstore);
                end
            end
            stalled_prev = dwait;
            prev_addr = daddr;
        end else begin
            dwait = 1'b0;
            stalled_prev = 0;
            stall_cnt = 0;
        end
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] got);
        logic [2:0]  s;
        logic [25:0] t;
        logic [31:0] exp_rd;
        logic [31:0] ea[$], ed[$];
        int hw, v;
        bit miss, vd;
        s = a[5:3];
        t = a[31:6];
        hw = -1;
        vd = 0;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        miss = hw < 0;
        exp_rd = gold_rd(a);
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();
        nstall = 0;
        if (miss) begin
            v = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : (m_time[s][0] < m_time[s][1] ? 0 : 1);
            vd = m_valid[s][v] && m_dirty[s][v];
            if (vd)
                for (int w = 0; w < 2; w++) begin
                    ea.push_back({m_tag[s][v], s, w[0], 2'b00});
                    ed.push_back(gold_rd({m_tag[s][v], s, w[0], 2'b00}));
                end
            m_valid[s][v] = 1;
            m_tag[s][v] = t;
            m_dirty[s][v] = 0;
            hw = v;
        end
        dmemREN = !wr;
        dmemWEN = wr;
        dmemaddr = a;
        dmemstore = wd;
        lat = 0;
        forever begin
            @(negedge CLK);
            if (dhit) break;
            mem_cycle();
            @(posedge CLK);
            #1;
            lat++;
            if (lat > 200) begin
                chk("hit_timeout", 32'(lat), 0);
                break;
            end
        end
        got = dmemload;
        @(posedge CLK);
        #1;
        dmemREN = 0;
        dmemWEN = 0;
        chk("latency", 32'(lat), miss ? 32'(1 + (vd ? 4 : 2) + nstall) : 0);
        chk("n_rd", 32'(rd_log.size()), miss ? 2 : 0);
        if (miss && rd_log.size() == 2) begin
            chk("rd_addr0", rd_log[0], {t, s, 3'b000});
            chk("rd_addr1", rd_log[1], {t, s, 3'b100});
        end
        chk("n_wr", 32'(wr_log.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < wr_log.size(); i++) begin
            chk("wb_addr", wr_log[i], ea[i]);
            chk("wb_data", wd_log[i], ed[i]);
        end
        chk(wr ? "wr_load_zero" : "rd_data", got, wr ? 32'h0 : exp_rd);
        now_t++;
        m_time[s][hw] = now_t;
        if (wr) begin
            m_dirty[s][hw] = 1;
            gold[a[31:2]] = wd;
        end
    endtask

    task automatic flush_check();
        logic [31:0] ea[$], ed[$];
        int cyc;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_dirty[s][w])
                    for (int k = 0; k < 2; k++) begin
                        ea.push_back({m_tag[s][w], s[2:0], k[0], 2'b00});
                        ed.push_back(gold_rd({m_tag[s][w], s[2:0], k[0], 2'b00}));
                    end
        wr_log.delete();
        wd_log.delete();
        rd_log.delete();
        nstall = 0;
        halt = 1;
        cyc = 0;
        forever begin
            @(negedge CLK);
            if (flushed) break;
            mem_cycle();
            @(posedge CLK);
            #1;
            cyc++;
            if (cyc > 2000) begin
                chk("flush_timeout", 32'(cyc), 0);
                break;
            end
        end
        chk("flush_cycles", 32'(cyc), 32'(17 + ea.size() / 2 + nstall));
        chk("flush_n_rd", 32'(rd_log.size()), 0);
        chk("flush_n_wr", 32'(wr_log.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < wr_log.size(); i++) begin
            chk("flush_addr", wr_log[i], ea[i]);
            chk("flush_data", wd_log[i], ed[i]);
        end
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) m_dirty[s][w] = 0;
        halt = 0;
        dmemREN = 1;
        dmemaddr = 32'h0000_0008;
        repeat (3) begin
            @(negedge CLK);
            chk("flushed_held", 32'(flushed), 1);
            chk("flushed_no_hit", 32'(dhit), 0);
            chk("flushed_no_mem", 32'(dREN | dWEN), 0);
            @(posedge CLK);
            #1;
        end
        dmemREN = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        halt = 0;
        dmemREN = 0;
        dmemWEN = 0;
        dwait = 0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1;
        model_clear();
    endtask

    initial begin
        int lat;
        logic [31:0] got, a, wd;
        bit w;
        nRST = 0; halt = 0; dmemREN = 0; dmemWEN = 0; dwait = 0;
        dmemaddr = '0; dmemstore = '0; dload = '0;
        #1;
        chk("rst_dhit", 32'(dhit), 0);
        chk("rst_flushed", 32'(flushed), 0);
        chk("rst_dren", 32'(dREN), 0);
        chk("rst_dwen", 32'(dWEN), 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dmemload", dmemload, 0);
        mem[30'h10] = 32'hAAAA_0001;
        mem[30'h11] = 32'hAAAA_0002;
        do_reset();

        access(0, 32'h40, 0, lat, got);
        chk("tp1_lat", 32'(lat), 3);
        chk("tp1_data", got, 32'hAAAA_0001);
        access(0, 32'h44, 0, lat, got);
        chk("tp1_hit_lat", 32'(lat), 0);
        chk("tp1_hit_data", got, 32'hAAAA_0002);

        access(1, 32'h40, 32'h1234_5678, lat, got);
        chk("tp2_wr_hit_lat", 32'(lat), 0);
        access(0, 32'h40, 0, lat, got);
        chk("tp2_rd_after_wr", got, 32'h1234_5678);
        access(0, 32'h80, 0, lat, got);
        access(0, 32'hC0, 0, lat, got);
        chk("tp2_dirty_lat", 32'(lat), 5);
        chk("tp2_wb0", wr_log.size() > 0 ? wd_log[0] : 32'h0, 32'h1234_5678);
        chk("tp2_wb1", wr_log.size() > 1 ? wr_log[1] : 32'h0, 32'h44);

        do_reset();
        access(0, 32'h40, 0, lat, got);
        access(0, 32'h80, 0, lat, got);
        access(0, 32'h40, 0, lat, got);
        chk("tp3_mru_hit", 32'(lat), 0);
        access(0, 32'hC0, 0, lat, got);
        chk("tp3_clean_evict_lat", 32'(lat), 3);
        access(0, 32'h40, 0, lat, got);
        chk("tp3_kept_hit", 32'(lat), 0);
        access(0, 32'h80, 0, lat, got);
        chk("tp3_evicted_miss", 32'(lat), 3);

        stall_per = 3;
        access(0, 32'h10, 0, lat, got);
        chk("tp4_stretch_lat", 32'(lat), 9);
        stall_per = 0;

        rnd = 1;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 3) |
                ($urandom_range(0, 1) << 2) | ($urandom_range(0, 1) << 20);
            w = 1'($urandom_range(0, 1));
            wd = $urandom;
            access(w, a, wd, lat, got);
        end
        flush_check();
        rnd = 0;

        do_reset();
        access(0, 32'h08, 0, lat, got);
        access(1, 32'h48, 32'hDEAD_0048, lat, got);
        access(1, 32'h28, 32'hBEEF_0028, lat, got);
        flush_check();
        chk("tp5_n_wr", 32'(wr_log.size()), 4);
        chk("tp5_first", wr_log.size() > 0 ? wr_log[0] : 32'h0, 32'h48);
        chk("tp5_third", wr_log.size() > 2 ? wr_log[2] : 32'h0, 32'h28);

        do_reset();
        dmemREN = 1;
        dmemaddr = 32'h100;
        lat = 0;
        forever begin
            @(negedge CLK);
            if (dREN && daddr[2]) break;
            mem_cycle();
            @(posedge CLK);
            #1;
            lat++;
            if (lat > 20) begin
                chk("ld1_timeout", 32'(lat), 0);
                break;
            end
        end
        nRST = 0;
        #1;
        chk("mid_rst_dhit", 32'(dhit), 0);
        chk("mid_rst_dren", 32'(dREN), 0);
        chk("mid_rst_dwen", 32'(dWEN), 0);
        chk("mid_rst_daddr", daddr, 0);
        chk("mid_rst_dstore", dstore, 0);
        chk("mid_rst_dmemload", dmemload, 0);
        chk("mid_rst_flushed", 32'(flushed), 0);
        dmemREN = 0;
        @(posedge CLK);
        #1;
        nRST = 1;
        model_clear();
        access(0, 32'h100, 0, lat, got);
        chk("mid_rst_refill_lat", 32'(lat), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
